// File: rtl/log_norm.sv
// Log-domain front-end normaliser: subtracts the ln(k/2) mixture correction, then
// left-shifts one bit per cycle until the MSB is set. Reports the shift count.
module log_norm #(
    parameter int WIDTH    = 21,
    parameter int MAXSHIFT = 15,
    parameter int CNTW     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       mixture_num,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] norm_out,
    output logic [CNTW-1:0]  shift_num,
    output logic             zero,
    output logic             underflow
);

    typedef enum logic [1:0] {IDLE, SUB, NORM, DONE} state_t;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXSHIFT);

    // ln(k/2) in Q15; entries 0 and 1 carry no correction
    function automatic logic [WIDTH-1:0] ln_const(input logic [2:0] m);
        case (m)
            3'd2:    ln_const = WIDTH'(20'h033E6);
            3'd3:    ln_const = WIDTH'(20'h058B9);
            3'd4:    ln_const = WIDTH'(20'h07549);
            3'd5:    ln_const = WIDTH'(20'h08C9F);
            3'd6:    ln_const = WIDTH'(20'h0A05A);
            3'd7:    ln_const = WIDTH'(20'h0B172);
            default: ln_const = '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [2:0]       mix_q, mix_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             zr_q, zr_d;
    logic             uf_q, uf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] norm_q, norm_d;
    logic [CNTW-1:0]  shift_q, shift_d;
    logic             zero_q, zero_d;
    logic             under_q, under_d;

    // Extra top bit holds the borrow of the subtraction
    logic [WIDTH:0]   diff;

    assign diff = {1'b0, din_q} - {1'b0, ln_const(mix_q)};

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        mix_d   = mix_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zr_d    = zr_q;
        uf_d    = uf_q;
        done_d  = 1'b0;
        norm_d  = norm_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        under_d = under_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    din_d   = data_in;
                    mix_d   = mixture_num;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (diff[WIDTH]) begin
                    work_d  = '0;
                    zr_d    = 1'b1;
                    uf_d    = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = DONE;
                end else if (diff[WIDTH-1:0] == '0) begin
                    work_d  = '0;
                    zr_d    = 1'b1;
                    uf_d    = 1'b0;
                    cnt_d   = CNT_MAX;
                    state_d = DONE;
                end else begin
                    work_d  = diff[WIDTH-1:0];
                    zr_d    = 1'b0;
                    uf_d    = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (work_q[WIDTH-1] || cnt_q == CNT_MAX) begin
                    state_d = DONE;
                end else begin
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Results are published together with the done pulse
                done_d  = 1'b1;
                norm_d  = work_q;
                shift_d = cnt_q;
                zero_d  = zr_q;
                under_d = uf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            din_q   <= '0;
            mix_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            zr_q    <= 1'b0;
            uf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            norm_q  <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            mix_q   <= mix_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zr_q    <= zr_d;
            uf_q    <= uf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            norm_q  <= norm_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
            under_q <= under_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign norm_out  = norm_q;
    assign shift_num = shift_q;
    assign zero      = zero_q;
    assign underflow = under_q;

endmodule

// File: tb/tb_log_norm.sv
// Directed bench for log_norm: hand-computed vectors, latency, busy-ignore and reset abort.
module tb_log_norm;

    logic        clk;
    logic        reset;
    logic        start;
    logic [20:0] data_in;
    logic [2:0]  mixture_num;
    logic        busy;
    logic        done;
    logic [20:0] norm_out;
    logic [3:0]  shift_num;
    logic        zero;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    log_norm #(.WIDTH(21), .MAXSHIFT(15), .CNTW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .mixture_num(mixture_num),
        .busy       (busy),
        .done       (done),
        .norm_out   (norm_out),
        .shift_num  (shift_num),
        .zero       (zero),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_norm"}, 32'(norm_out), 32'd0);
        check({tag, "_shift"}, 32'(shift_num), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd0);
        check({tag, "_uf"}, 32'(underflow), 32'd0);
    endtask

    // Launch one operation, count edges from the start-sampling edge to done.
    task automatic run_op(input string tag, input logic [20:0] d, input logic [2:0] m,
                          input int exp_lat, input logic [20:0] exp_norm,
                          input logic [3:0] exp_sh, input logic exp_z,
                          input logic exp_u, input bit repulse);
        int lat;
        lat = -1;
        @(negedge clk);
        data_in     = d;
        mixture_num = m;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            if (repulse && i == 5) begin
                start       = 1'b1;
                data_in     = 21'h10000;
                mixture_num = 3'd0;
            end
            @(posedge clk);
            #1;
            if (repulse && i == 5) begin
                start = 1'b0;
                check({tag, "_busy_at_repulse"}, 32'(busy), 32'd1);
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_norm"}, 32'(norm_out), 32'(exp_norm));
        check({tag, "_shift"}, 32'(shift_num), 32'(exp_sh));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
        check({tag, "_uf"}, 32'(underflow), 32'(exp_u));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold_norm"}, 32'(norm_out), 32'(exp_norm));
        check({tag, "_hold_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen_done;
        reset       = 1'b1;
        start       = 1'b0;
        data_in     = '0;
        mixture_num = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_op("m0_pow2", 21'h10000,  3'd0, 7,  21'h100000, 4'd4,  1'b0, 1'b0, 1'b0);
        run_op("m2_sub",  21'h100000, 3'd2, 4,  21'h1F9834, 4'd1,  1'b0, 1'b0, 1'b0);
        run_op("m7_zero", 21'h0B172,  3'd7, 2,  21'h0,      4'd15, 1'b1, 1'b0, 1'b0);
        run_op("m4_uf",   21'h058B9,  3'd4, 2,  21'h0,      4'd15, 1'b1, 1'b1, 1'b0);
        run_op("m0_sat",  21'h00001,  3'd0, 18, 21'h08000,  4'd15, 1'b0, 1'b0, 1'b1);
        run_op("m0_sat2", 21'h00001,  3'd0, 18, 21'h08000,  4'd15, 1'b0, 1'b0, 1'b0);
        run_op("m1_msb",  21'h1ABCDE, 3'd1, 3,  21'h1ABCDE, 4'd0,  1'b0, 1'b0, 1'b0);

        // Abort an operation mid-NORM with an asynchronous reset
        @(negedge clk);
        data_in     = 21'h00001;
        mixture_num = 3'd0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        run_op("recover", 21'h058B9, 3'd3, 2, 21'h0, 4'd15, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
